// File: rtl/ram2_arbiter_pkg.sv
// ram2_arbiter_pkg
// Shared definitions for the RAM2 arbiter: FSM state encoding, the number of
// SRAM bus cycles each access occupies (ready follows one cycle later), and
// the granted-port encoding.
package ram2_arbiter_pkg;

  // Cycles the SRAM is occupied by one access, excluding the IDLE/ready cycle.
  localparam int READ_CYCLES  = 2;
  localparam int WRITE_CYCLES = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ADDR  = 3'd1,
    RD_LATCH = 3'd2,
    WR_ADDR  = 3'd3,
    WR_PULSE = 3'd4,
    WR_HOLD  = 3'd5
  } state_t;

  typedef enum logic {
    GRANT_IF  = 1'b0,
    GRANT_MEM = 1'b1
  } grant_t;

endpackage

// File: rtl/ram2_arbiter_if.sv
// ram2_arbiter_if
// Requester-side bus of the RAM2 arbiter: the instruction-fetch port (if_*)
// and the data port (mem_*).
//   master : the CPU side, drives requests, receives ready/data/stall
//   slave  : the arbiter side
interface ram2_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_instr;
  logic        if_ready;
  logic        if_stall;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    input  if_instr, if_ready, if_stall, mem_rdata, mem_ready
  );

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    output if_instr, if_ready, if_stall, mem_rdata, mem_ready
  );
endinterface

// File: rtl/ram2_arbiter.sv
// ram2_arbiter
// Shares one asynchronous SRAM (RAM2) between an instruction-fetch port and a
// data port. Priority in IDLE is mem_wr > mem_rd > if_req; once granted, an
// access runs to completion (read: 2 SRAM cycles, write: 3) and ends with a
// single-cycle ready pulse to the granted port only.
// Ports:
//   CLK       : sole clock, rising edge
//   RST       : asynchronous active-high reset
//   bus       : requester bus (ram2_arbiter_if.slave)
//   RAM2OE/WE : active-low SRAM output/write enables (registered)
//   RAM2EN    : active-low SRAM chip enable, low whenever not in reset
//   RAM2ADDR  : {2'b00, latched 16-bit address}
//   RAM2DATA  : SRAM data bus, driven only in the write states
module ram2_arbiter
  import ram2_arbiter_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  ram2_arbiter_if.slave         bus,
  output logic                  RAM2OE,
  output logic                  RAM2WE,
  output logic                  RAM2EN,
  output logic [17:0]           RAM2ADDR,
  inout  wire  [15:0]           RAM2DATA
);

  state_t      state_r;
  grant_t      grant_r;
  logic [15:0] addr_r;
  logic [15:0] wdata_r;
  logic        oe_r;
  logic        we_r;
  logic        drive_r;
  logic        if_ready_r;
  logic        mem_ready_r;
  logic [15:0] if_instr_r;
  logic [15:0] mem_rdata_r;

  // Access FSM with registered SRAM controls, ready pulses and read data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r     <= IDLE;
      grant_r     <= GRANT_IF;
      addr_r      <= 16'h0000;
      wdata_r     <= 16'h0000;
      oe_r        <= 1'b1;
      we_r        <= 1'b1;
      drive_r     <= 1'b0;
      if_ready_r  <= 1'b0;
      mem_ready_r <= 1'b0;
      if_instr_r  <= 16'h0000;
      mem_rdata_r <= 16'h0000;
    end else begin
      // Ready is a one-cycle pulse; only the completing state raises it.
      if_ready_r  <= 1'b0;
      mem_ready_r <= 1'b0;
      case (state_r)
        IDLE: begin
          // A write wins even when mem_rd is also high, so no read cycle occurs.
          if (bus.mem_wr) begin
            grant_r <= GRANT_MEM;
            addr_r  <= bus.mem_addr;
            wdata_r <= bus.mem_wdata;
            drive_r <= 1'b1;
            state_r <= WR_ADDR;
          end else if (bus.mem_rd) begin
            grant_r <= GRANT_MEM;
            addr_r  <= bus.mem_addr;
            oe_r    <= 1'b0;
            state_r <= RD_ADDR;
          end else if (bus.if_req) begin
            grant_r <= GRANT_IF;
            addr_r  <= bus.if_addr;
            oe_r    <= 1'b0;
            state_r <= RD_ADDR;
          end else begin
            state_r <= IDLE;
          end
        end
        RD_ADDR: begin
          state_r <= RD_LATCH;
        end
        RD_LATCH: begin
          oe_r    <= 1'b1;
          state_r <= IDLE;
          if (grant_r == GRANT_MEM) begin
            mem_rdata_r <= RAM2DATA;
            mem_ready_r <= 1'b1;
          end else begin
            if_instr_r <= RAM2DATA;
            if_ready_r <= 1'b1;
          end
        end
        WR_ADDR: begin
          we_r    <= 1'b0;
          state_r <= WR_PULSE;
        end
        WR_PULSE: begin
          we_r    <= 1'b1;
          state_r <= WR_HOLD;
        end
        WR_HOLD: begin
          // Data stays driven through HOLD to cover SRAM data hold time.
          drive_r     <= 1'b0;
          mem_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          oe_r    <= 1'b1;
          we_r    <= 1'b1;
          drive_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign RAM2DATA = drive_r ? wdata_r : 16'hzzzz;
  assign RAM2OE   = oe_r;
  assign RAM2WE   = we_r;
  assign RAM2EN   = RST;
  assign RAM2ADDR = {2'b00, addr_r};

  assign bus.if_instr  = if_instr_r;
  assign bus.if_ready  = if_ready_r;
  assign bus.mem_rdata = mem_rdata_r;
  assign bus.mem_ready = mem_ready_r;
  // Combinational so the CPU can freeze in the same cycle it requests.
  assign bus.if_stall  = bus.if_req & ~if_ready_r;

endmodule

// File: tb/tb_ram2_arbiter.sv
// tb_ram2_arbiter
// Directed bench for ram2_arbiter with a behavioural SRAM on RAM2.
module tb_ram2_arbiter;
  import ram2_arbiter_pkg::*;

  logic        CLK;
  logic        RST;
  wire  [15:0] RAM2DATA;
  logic        RAM2OE, RAM2WE, RAM2EN;
  logic [17:0] RAM2ADDR;

  ram2_arbiter_if bus();

  ram2_arbiter dut (
    .CLK(CLK), .RST(RST), .bus(bus),
    .RAM2OE(RAM2OE), .RAM2WE(RAM2WE), .RAM2EN(RAM2EN),
    .RAM2ADDR(RAM2ADDR), .RAM2DATA(RAM2DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM model: drives the bus while OE is low, stores while WE is low.
  logic [15:0] sram [0:65535];
  logic [15:0] sram_q;
  assign sram_q   = sram[RAM2ADDR[15:0]];
  assign RAM2DATA = (RAM2OE === 1'b0) ? sram_q : 16'hzzzz;

  int n_cmp = 0;
  int n_bad = 0;

  int oe_cnt, we_cnt, drv_cnt, stall_cnt, addr_bad, if_rdy_cnt, mem_rdy_cnt;
  int both_low = 0;
  logic [15:0] mon_addr;

  always @(negedge CLK) begin
    if (RAM2OE === 1'b0) oe_cnt++;
    if (RAM2WE === 1'b0) we_cnt++;
    if (RAM2OE === 1'b1 && RAM2DATA !== 16'hzzzz) drv_cnt++;
    if (RAM2OE === 1'b0 && RAM2WE === 1'b0) both_low++;
    if ((RAM2OE === 1'b0 || RAM2WE === 1'b0 || (RAM2OE === 1'b1 && RAM2DATA !== 16'hzzzz))
        && RAM2ADDR !== {2'b00, mon_addr}) addr_bad++;
    if (bus.if_stall === 1'b1) stall_cnt++;
    if (bus.if_ready === 1'b1) if_rdy_cnt++;
    if (bus.mem_ready === 1'b1) mem_rdy_cnt++;
    if (RST === 1'b0 && RAM2WE === 1'b0) sram[RAM2ADDR[15:0]] = RAM2DATA;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mon(input logic [15:0] a);
    oe_cnt = 0; we_cnt = 0; drv_cnt = 0; stall_cnt = 0; addr_bad = 0;
    if_rdy_cnt = 0; mem_rdy_cnt = 0; mon_addr = a;
  endtask

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.mem_rd = 1'b0; bus.mem_wr = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic        rd;
    logic        ifr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
  } vec_t;

  // One complete access from IDLE; called #1 after an active edge.
  task automatic run_access(input vec_t v);
    int   n;
    int   exp_lat;
    logic got;
    logic is_write;
    logic to_mem;
    is_write = v.wr;
    to_mem   = v.wr | v.rd;
    exp_lat  = is_write ? WRITE_CYCLES + 1 : READ_CYCLES + 1;
    clear_mon(v.addr);
    bus.mem_wr = v.wr; bus.mem_rd = v.rd; bus.if_req = v.ifr;
    bus.mem_addr = v.addr; bus.mem_wdata = v.wdata; bus.if_addr = v.addr;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      got = to_mem ? bus.mem_ready : bus.if_ready;
    end
    chk({v.name, " latency"}, n, exp_lat);
    if (!is_write)
      chk({v.name, " rdata"}, to_mem ? bus.mem_rdata : bus.if_instr, v.exp_data);
    idle_inputs();
    chk({v.name, " oe_low"}, oe_cnt, is_write ? 0 : READ_CYCLES);
    chk({v.name, " we_low"}, we_cnt, is_write ? 1 : 0);
    chk({v.name, " bus_driven"}, drv_cnt, is_write ? WRITE_CYCLES : 0);
    chk({v.name, " stall"}, stall_cnt, v.ifr && !to_mem ? READ_CYCLES + 1 : 0);
    tick();
    chk({v.name, " ready_pulse"}, {bus.if_ready, bus.mem_ready}, 2'b00);
    chk({v.name, " addr_stable"}, addr_bad, 0);
    chk({v.name, " ready_routing"}, {if_rdy_cnt[7:0], mem_rdy_cnt[7:0]},
        to_mem ? 16'h0001 : 16'h0100);
  endtask

  vec_t vecs[8];
  int   mem_at, if_at, if_pulses, first_if;

  initial begin
    sram[16'h0010] = 16'h4A21;
    sram[16'h0000] = 16'hA5A5;
    sram[16'h2222] = 16'h7777;
    idle_inputs();
    bus.if_addr = 16'h0000; bus.mem_addr = 16'h0000; bus.mem_wdata = 16'h0000;
    mon_addr = 16'h0000;
    clear_mon(16'h0000);

    vecs[0] = '{"if_rd_0010",   1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'h4A21};
    vecs[1] = '{"mem_wr_8000",  1'b1, 1'b0, 1'b0, 16'h8000, 16'hBEEF, 16'h0000};
    vecs[2] = '{"mem_rd_8000",  1'b0, 1'b1, 1'b0, 16'h8000, 16'h0000, 16'hBEEF};
    vecs[3] = '{"rdwr_1234",    1'b1, 1'b1, 1'b0, 16'h1234, 16'h5A5A, 16'h0000};
    vecs[4] = '{"if_rd_1234",   1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 16'h5A5A};
    vecs[5] = '{"mem_wr_ffff",  1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000};
    vecs[6] = '{"mem_rd_ffff",  1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0001};
    vecs[7] = '{"if_rd_0000",   1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'hA5A5};

    // Asynchronous reset, checked before the first clock edge.
    RST = 1'b0;
    #1 RST = 1'b1;
    #1;
    chk("rst_ctrl", {RAM2OE, RAM2WE, RAM2EN}, 3'b111);
    chk("rst_data_z", RAM2DATA === 16'hzzzz, 1'b1);
    chk("rst_ready", {bus.if_ready, bus.mem_ready}, 2'b00);
    chk("rst_regs", {bus.if_instr, bus.mem_rdata}, 32'h0000_0000);
    chk("rst_addr", RAM2ADDR, 18'h00000);
    tick(); tick();
    RST = 1'b0;
    #1;
    chk("en_after_rst", RAM2EN, 1'b0);
    tick();

    for (int i = 0; i < 8; i++) run_access(vecs[i]);

    // Fetch and data read requested together: data port first, fetch waits.
    clear_mon(16'h8000);
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    bus.mem_rd = 1'b1; bus.mem_addr = 16'h8000;
    mem_at = 0; if_at = 0;
    for (int c = 1; c <= 12 && if_at == 0; c++) begin
      tick();
      if (bus.mem_ready === 1'b1) begin
        mem_at = c;
        chk("prio_mem_data", bus.mem_rdata, 16'hBEEF);
        bus.mem_rd = 1'b0;
        mon_addr = 16'h0010;
      end
      if (bus.if_ready === 1'b1) begin
        if_at = c;
        chk("prio_if_data", bus.if_instr, 16'h4A21);
        bus.if_req = 1'b0;
      end
    end
    chk("prio_mem_at", mem_at, 3);
    chk("prio_if_at", if_at, 6);
    chk("prio_stall", stall_cnt, 6);
    chk("prio_addr_stable", addr_bad, 0);
    idle_inputs();
    tick();

    // Fetch request held across ready: treated as a new request each time.
    clear_mon(16'h0010);
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    if_pulses = 0; first_if = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (bus.if_ready === 1'b1) begin
        if_pulses++;
        if (first_if == 0) first_if = c;
      end
    end
    idle_inputs();
    chk("b2b_pulses", if_pulses, 2);
    chk("b2b_first", first_if, 3);
    chk("b2b_oe_low", oe_cnt, 4);
    tick();

    // Reset during WR_PULSE aborts the write with no ready.
    clear_mon(16'h2222);
    bus.mem_wr = 1'b1; bus.mem_addr = 16'h2222; bus.mem_wdata = 16'h1111;
    tick(); tick();
    chk("abort_in_pulse", RAM2WE, 1'b0);
    #1 RST = 1'b1;
    idle_inputs();
    #1;
    chk("abort_we_oe", {RAM2WE, RAM2OE}, 2'b11);
    chk("abort_data_z", RAM2DATA === 16'hzzzz, 1'b1);
    chk("abort_ready", {bus.if_ready, bus.mem_ready}, 2'b00);
    tick();
    RST = 1'b0;
    tick(); tick();
    chk("abort_no_ready", mem_rdy_cnt, 0);
    run_access(vecs[0]);

    chk("oe_we_never_both_low", both_low, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram2_arbiter.md
RAM2_ARBITER -- requirements
Module: ram2_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port if_req, input, 1, fetch request, held until if_ready.
REQ-004 SHALL have port if_addr, input, 16, fetch word address.
REQ-005 SHALL have port if_instr, output, 16, registered fetched instruction.
REQ-006 SHALL have port if_ready, output, 1, one-cycle fetch completion pulse.
REQ-007 SHALL have port if_stall, output, 1, combinational if_req AND NOT if_ready.
REQ-008 SHALL have ports mem_rd and mem_wr, input, 1 each, data-port read/write request, held until mem_ready.
REQ-009 SHALL have ports mem_addr and mem_wdata, input, 16 each.
REQ-010 SHALL have port mem_rdata, output, 16, registered read data.
REQ-011 SHALL have port mem_ready, output, 1, one-cycle data-port completion pulse.
REQ-012 SHALL have ports RAM2OE, RAM2WE, RAM2EN, output, 1 each, active-low SRAM controls.
REQ-013 SHALL have port RAM2ADDR, output, 18, {2'b00, selected 16-bit address}.
REQ-014 SHALL have port RAM2DATA, inout, 16, SRAM data bus.

Function
REQ-015 SHALL implement states IDLE, RD_ADDR, RD_LATCH, WR_ADDR, WR_PULSE, WR_HOLD.
REQ-016 In IDLE, priority SHALL be mem_wr > mem_rd > if_req; the granted port and its address/wdata SHALL be registered at the accepting edge.
REQ-017 Read: IDLE -> RD_ADDR -> RD_LATCH -> IDLE; RAM2OE=0 in RD_ADDR and RD_LATCH; RAM2DATA sampled into if_instr or mem_rdata at the edge leaving RD_LATCH.
REQ-018 Write: IDLE -> WR_ADDR -> WR_PULSE -> WR_HOLD -> IDLE; RAM2WE=0 only in WR_PULSE; RAM2DATA driven with latched wdata in all three WR states.
REQ-019 RAM2DATA SHALL be high-Z in every non-WR state; RAM2OE and RAM2WE SHALL never be low simultaneously.
REQ-020 RAM2ADDR SHALL be stable from the first through the last state of an access.
REQ-021 Read latency: request seen at edge N -> ready high in cycle after edge N+2, data valid with it; write: ready after edge N+3.
REQ-022 Ready SHALL be registered, asserted exactly one cycle, and only to the granted port.
REQ-023 A request present in the IDLE cycle in which ready is high SHALL be treated as new (back-to-back: read every 3 cycles, write every 4).
REQ-024 A lower-priority request SHALL wait in IDLE without side effects; an access in progress SHALL never be pre-empted.
REQ-025 Simultaneous mem_rd and mem_wr SHALL be serviced as a write only.
REQ-026 RAM2EN SHALL be 0 whenever not in reset.

Reset
REQ-027 On RST high, immediately: state=IDLE, RAM2OE=1, RAM2WE=1, RAM2EN=1, RAM2DATA high-Z, if_ready=0, mem_ready=0, if_instr=0, mem_rdata=0, RAM2ADDR=0.
REQ-028 RST asserted mid-access SHALL abort it with no ready pulse; first request accepted at the first edge after RST deasserts.

Structure
REQ-029 State encoding and access-length constants (READ_CYCLES=2, WRITE_CYCLES=3) SHALL reside in a shared package.
REQ-030 No sub-module required; tri-state bus driver SHALL be inline.

Verification
REQ-031 if_req=1, if_addr=0x0010, SRAM[0x0010]=0x4A21 -> RAM2OE low 2 cycles, if_ready pulse 3rd cycle, if_instr=0x4A21.
REQ-032 mem_wr=1, mem_addr=0x8000, mem_wdata=0xBEEF -> RAM2WE low exactly 1 cycle, bus driven 3 cycles, mem_ready pulse; following read of 0x8000 returns 0xBEEF.
REQ-033 if_req and mem_rd both asserted at same edge -> mem served first, if_stall high 6 cycles, if_ready after mem_ready.
REQ-034 mem_rd and mem_wr both high -> single write, no read cycle, RAM2OE stays high.
REQ-035 RST pulse during WR_PULSE -> RAM2WE=1, bus Z immediately, no mem_ready; next read post-reset completes normally.
